bc_orbit_counter: RTL and testbench
===================================

Name: bc_orbit_counter

Overview:
Parametrised bunch/orbit counter for the digitizer timing path.
- BC counts 0..ORBIT_LEN-1 and wraps; the orbit counter ORB increments on each wrap.
- An external BC0 marker aligns the counter, with lock tracking and misalignment detection.
- EC0 clears the orbit count.
- Feeds timestamping of digitizer samples and readout headers.

Parameters:
BITS, 12, width of BC output; must satisfy 2^BITS >= ORBIT_LEN
ORBIT_LEN, 3564, bunch slots per orbit; wrap point is ORBIT_LEN-1
BC0_OFFSET, 0, BC value loaded on the cycle after a BC0_IN pulse; must be < ORBIT_LEN
ORB_BITS, 32, width of orbit counter
MISS_MAX, 3, consecutive orbits without BC0_IN before lock is dropped (1..15)

Ports:
CLK  in  1  bunch clock
RST  in  1  asynchronous active-high reset
EN  in  1  count enable; when low, BC/ORB hold and the miss counter holds
BC0_IN  in  1  single-cycle orbit marker (synchronous to CLK)
EC0_IN  in  1  single-cycle orbit-count reset (synchronous)
BC  out  BITS  current bunch count
ORB  out  ORB_BITS  current orbit count
BC0_OUT  out  1  registered pulse, high while BC==0
LOCKED  out  1  high in LOCKED state
BC0_ERR  out  1  single-cycle pulse: BC0_IN arrived misaligned while LOCKED
ERR_CNT  out  16  misalignment count (see Optional Feature)

Behaviour:
- Reset (async assert, sync release on CLK):
  - BC=0, ORB=0, BC0_OUT=1, LOCKED=0, BC0_ERR=0, ERR_CNT=0.
  - Miss counter=0, state=UNLOCKED.
- All outputs are registered. An input event at edge n is visible after edge n.
- Counting (EN=1, no BC0_IN):
  - BC <= (BC==ORBIT_LEN-1) ? 0 : BC+1.
  - On the wrap, ORB <= ORB+1, modulo 2^ORB_BITS.
- BC0_IN=1 at edge n: BC=BC0_OFFSET after edge n, regardless of EN.
  - "Aligned" means the count BC would have reached anyway equals BC0_OFFSET, i.e. BC==(BC0_OFFSET-1) mod ORBIT_LEN.
- ORB update during a BC0_IN load: ORB increments only if the load crosses the wrap. This holds when BC0_OFFSET==0 and the prior BC!=0, or when the aligned case wraps naturally.
- EC0_IN: ORB <= 0 on the next edge. Takes priority over any same-cycle increment. Ignores EN.
- FSM states UNLOCKED, LOCKED:
  - UNLOCKED: BC free-runs. On BC0_IN -> load, miss counter=0, go LOCKED. No BC0_ERR in this state.
  - LOCKED, aligned BC0_IN: no BC change, miss counter=0.
  - LOCKED, misaligned BC0_IN: load BC0_OFFSET, pulse BC0_ERR for 1 cycle, stay LOCKED, miss counter=0.
  - LOCKED, each wrap of BC to 0 with no BC0_IN in the same cycle: miss counter+1. When it reaches MISS_MAX -> UNLOCKED, miss counter=0.
- BC0_OUT = (next BC==0), registered, so it is high exactly while BC==0.
- Simultaneous BC0_IN and EC0_IN: both apply (BC loaded, ORB=0).
- Simultaneous BC0_IN and RST: RST wins.
- EN=0: BC0_IN still loads BC0_OFFSET and updates the FSM. The miss counter does not advance.
- RST mid-orbit: immediate return to reset values; lock is lost.

Optional Feature:
Macro BC_ERR_COUNT_EN.
- Defined: ERR_CNT is a 16-bit counter.
  - Increments on each BC0_ERR pulse, saturating at 16'hFFFF.
  - Also increments on each LOCKED->UNLOCKED transition due to misses.
  - Both events in the same cycle count as one.
  - Cleared only by RST.
- Undefined: ERR_CNT tied to 16'h0000, no counter logic. The port remains present.

Decomposition:
- Package bc_pkg:
  - lock state enum (UNLOCKED, LOCKED)
  - default constants ORBIT_LEN_DEF=3564, ERR_CNT_W=16
  - function computing the BC0 pre-alignment value ((BC0_OFFSET+ORBIT_LEN-1) % ORBIT_LEN)
- One sub-module, bc_lock_fsm:
  - Inputs: BC0_IN, wrap strobe, aligned flag, EN.
  - Outputs: LOCKED, BC0_ERR, load strobe, loss strobe.
  - Contains the miss counter.
- BC/ORB datapath stays in the top.

Test Plan:
Unless stated otherwise, ORBIT_LEN=16, BITS=4, BC0_OFFSET=0, MISS_MAX=2.
1. Free-run: release RST, EN=1, 40 cycles -> BC sequence 0..15,0..15,0..7; ORB=2 at end; BC0_OUT high on the 3 cycles with BC==0; LOCKED=0.
2. Lock/aligned: BC0_IN at BC==15 -> LOCKED=1 next cycle, BC=0, no BC0_ERR. Repeat BC0_IN every 16 cycles for 4 orbits -> LOCKED stays 1, BC0_ERR never asserts.
3. Misalignment: while LOCKED, BC0_IN at BC==7 -> BC=0 next cycle, BC0_ERR pulses 1 cycle. With BC_ERR_COUNT_EN, ERR_CNT=1; without it, ERR_CNT=0.
4. Lock loss: lock, then withhold BC0_IN -> LOCKED falls after the 2nd wrap. With BC_ERR_COUNT_EN, ERR_CNT increments by 1.
5. EC0/priority: EC0_IN on a cycle where BC==15 -> ORB=0 (not +1). Separately, set BC0_OFFSET=5 and pulse BC0_IN with EN=0 -> BC=5 and held.
6. Async reset: assert RST mid-orbit between clock edges -> all outputs at reset values immediately. ORB_BITS=8 run of 256 orbits -> ORB wraps 255->0.

Source files
------------

// File: rtl/bc_orbit_counter_pkg.sv
// bc_pkg: shared types, defaults and helpers for the bunch/orbit counter.
//   lock_state_t   : lock FSM state encoding
//   ORBIT_LEN_DEF  : default bunch slots per orbit
//   ERR_CNT_W      : width of the misalignment counter port
//   bc0_pre_align(): BC value that, counted once more, lands on BC0_OFFSET
package bc_pkg;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    localparam int ORBIT_LEN_DEF = 3564;
    localparam int ERR_CNT_W     = 16;

    function automatic int bc0_pre_align(input int offset, input int orbit_len);
        return (offset + orbit_len - 1) % orbit_len;
    endfunction

endpackage

// File: rtl/bc_orbit_counter_lock_fsm.sv
// bc_lock_fsm: BC0 lock tracking for the bunch/orbit counter.
// Ports:
//   clk, rst    : clock, async active-high reset
//   bc0         : external orbit marker
//   wrap        : BC is at its last slot (would wrap on this edge if enabled)
//   aligned     : BC is at the pre-alignment value for BC0_OFFSET
//   en          : count enable; misses only advance while enabled
//   locked      : registered, high in LOCKED state
//   bc0_err     : registered one-cycle pulse on a misaligned marker while locked
//   load        : comb strobe, datapath loads BC0_OFFSET this edge
//   loss        : comb strobe, lock dropped due to missing markers this edge
//   err_stb     : comb strobe, a misalignment is being flagged this edge
module bc_lock_fsm
    import bc_pkg::*;
#(
    parameter int MISS_MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic bc0,
    input  logic wrap,
    input  logic aligned,
    input  logic en,
    output logic locked,
    output logic bc0_err,
    output logic load,
    output logic loss,
    output logic err_stb
);

    localparam logic [3:0] MISS_LAST = 4'(MISS_MAX - 1);

    lock_state_t state, state_next;
    logic [3:0]  miss, miss_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_UNLOCKED;
            miss    <= '0;
            bc0_err <= 1'b0;
        end else begin
            state   <= state_next;
            miss    <= miss_next;
            bc0_err <= err_stb;
        end
    end

    always_comb begin
        state_next = state;
        miss_next  = miss;
        err_stb    = 1'b0;
        load       = bc0;
        loss       = 1'b0;
        case (state)
            ST_UNLOCKED: begin
                if (bc0) begin
                    state_next = ST_LOCKED;
                    miss_next  = '0;
                end
            end
            ST_LOCKED: begin
                if (bc0) begin
                    miss_next = '0;
                    if (!aligned)
                        err_stb = 1'b1;
                    else if (en)
                        load = 1'b0;   // natural count already lands on the offset
                end else if (wrap && en) begin
                    if (miss == MISS_LAST) begin
                        state_next = ST_UNLOCKED;
                        miss_next  = '0;
                        loss       = 1'b1;
                    end else begin
                        miss_next = miss + 4'd1;
                    end
                end
            end
            default: state_next = ST_UNLOCKED;
        endcase
    end

    assign locked = (state == ST_LOCKED);

endmodule

// File: rtl/bc_orbit_counter.sv
// bc_orbit_counter: parametrised bunch (BC) / orbit (ORB) counter with BC0
// alignment, lock tracking and misalignment detection.
// Optional: define BC_ERR_COUNT_EN to build the saturating ERR_CNT counter;
// otherwise ERR_CNT is tied to zero.
// Ports:
//   CLK, RST : bunch clock, async active-high reset
//   EN       : count enable (BC0_IN/EC0_IN act regardless)
//   BC0_IN   : orbit marker, loads BC0_OFFSET
//   EC0_IN   : clears ORB
//   BC, ORB  : bunch and orbit counts
//   BC0_OUT  : high while BC==0
//   LOCKED   : lock state
//   BC0_ERR  : misaligned marker pulse
//   ERR_CNT  : misalignment / lock-loss count
module bc_orbit_counter
    import bc_pkg::*;
#(
    parameter int BITS       = 12,
    parameter int ORBIT_LEN  = ORBIT_LEN_DEF,
    parameter int BC0_OFFSET = 0,
    parameter int ORB_BITS   = 32,
    parameter int MISS_MAX   = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic                 BC0_IN,
    input  logic                 EC0_IN,
    output logic [BITS-1:0]      BC,
    output logic [ORB_BITS-1:0]  ORB,
    output logic                 BC0_OUT,
    output logic                 LOCKED,
    output logic                 BC0_ERR,
    output logic [ERR_CNT_W-1:0] ERR_CNT
);

    localparam logic [BITS-1:0] LAST      = BITS'(ORBIT_LEN - 1);
    localparam logic [BITS-1:0] OFFS      = BITS'(BC0_OFFSET);
    localparam logic [BITS-1:0] PRE       = BITS'(bc0_pre_align(BC0_OFFSET, ORBIT_LEN));
    localparam bit              OFFS_ZERO = (BC0_OFFSET == 0);

    logic                wrap, aligned, load, loss, err_stb, orb_inc;
    logic [BITS-1:0]     bc_next;
    logic [ORB_BITS-1:0] orb_next;

    assign wrap    = (BC == LAST);
    assign aligned = (BC == PRE);

    bc_lock_fsm #(.MISS_MAX(MISS_MAX)) u_fsm (
        .clk     (CLK),
        .rst     (RST),
        .bc0     (BC0_IN),
        .wrap    (wrap),
        .aligned (aligned),
        .en      (EN),
        .locked  (LOCKED),
        .bc0_err (BC0_ERR),
        .load    (load),
        .loss    (loss),
        .err_stb (err_stb)
    );

    always_comb begin
        bc_next = BC;
        orb_inc = 1'b0;
        if (load) begin
            bc_next = OFFS;
            // A jump to slot 0 from anywhere else crosses the orbit boundary.
            orb_inc = OFFS_ZERO && (BC != '0);
        end else if (EN) begin
            bc_next = wrap ? '0 : BC + BITS'(1);
            orb_inc = wrap;
        end
        orb_next = EC0_IN ? '0 : ORB + ORB_BITS'(orb_inc);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            BC      <= '0;
            ORB     <= '0;
            BC0_OUT <= 1'b1;
        end else begin
            BC      <= bc_next;
            ORB     <= orb_next;
            BC0_OUT <= (bc_next == '0);
        end
    end

`ifdef BC_ERR_COUNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            ERR_CNT <= '0;
        else if ((err_stb || loss) && (ERR_CNT != '1))
            ERR_CNT <= ERR_CNT + ERR_CNT_W'(1);
    end
`else
    logic unused_err;
    assign unused_err = err_stb ^ loss;
    assign ERR_CNT    = '0;
`endif

endmodule

// File: tb/tb_bc_orbit_counter.sv
// Directed bench: DUT a (ORBIT_LEN 16, offset 0, 32-bit ORB, MISS_MAX 2) and
// DUT b (ORBIT_LEN 16, offset 5, 8-bit ORB, MISS_MAX 2) share all inputs.
module tb_bc_orbit_counter;
    import bc_pkg::*;

`ifdef BC_ERR_COUNT_EN
    localparam int ERRC = 1;
`else
    localparam int ERRC = 0;
`endif

    logic clk = 1'b0, rst = 1'b1, en = 1'b0, bc0 = 1'b0, ec0 = 1'b0;
    logic [3:0]  a_bc, b_bc;
    logic [31:0] a_orb;
    logic [7:0]  b_orb;
    logic a_bc0_out, a_locked, a_bc0_err, b_bc0_out, b_locked, b_bc0_err;
    logic [15:0] a_err_cnt, b_err_cnt;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    bc_orbit_counter #(.BITS(4), .ORBIT_LEN(16), .BC0_OFFSET(0), .ORB_BITS(32), .MISS_MAX(2)) u_a (
        .CLK(clk), .RST(rst), .EN(en), .BC0_IN(bc0), .EC0_IN(ec0),
        .BC(a_bc), .ORB(a_orb), .BC0_OUT(a_bc0_out), .LOCKED(a_locked),
        .BC0_ERR(a_bc0_err), .ERR_CNT(a_err_cnt));

    bc_orbit_counter #(.BITS(4), .ORBIT_LEN(16), .BC0_OFFSET(5), .ORB_BITS(8), .MISS_MAX(2)) u_b (
        .CLK(clk), .RST(rst), .EN(en), .BC0_IN(bc0), .EC0_IN(ec0),
        .BC(b_bc), .ORB(b_orb), .BC0_OUT(b_bc0_out), .LOCKED(b_locked),
        .BC0_ERR(b_bc0_err), .ERR_CNT(b_err_cnt));

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; bc0 = 1'b0; ec0 = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (a_bc !== 4'd0) begin failures++; $display("FAIL reset_bc got=%0d exp=0", a_bc); end
        checks++; if (a_orb !== 32'd0) begin failures++; $display("FAIL reset_orb got=%0d exp=0", a_orb); end
        checks++; if (a_bc0_out !== 1'b1) begin failures++; $display("FAIL reset_bc0_out got=%b exp=1", a_bc0_out); end
        checks++; if (a_locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", a_locked); end
        checks++; if (a_bc0_err !== 1'b0) begin failures++; $display("FAIL reset_bc0_err got=%b exp=0", a_bc0_err); end
        checks++; if (a_err_cnt !== 16'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", a_err_cnt); end
    endtask

    task automatic test_free_run();
        en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            checks++; if (a_bc !== 4'(i % 16)) begin failures++; $display("FAIL free_bc i=%0d got=%0d exp=%0d", i, a_bc, i % 16); end
            checks++; if (a_bc0_out !== ((i % 16) == 0)) begin failures++; $display("FAIL free_bc0_out i=%0d got=%b exp=%b", i, a_bc0_out, (i % 16) == 0); end
            checks++; if (a_locked !== 1'b0) begin failures++; $display("FAIL free_locked i=%0d got=%b exp=0", i, a_locked); end
            if (i < 39) step(1);
        end
        checks++; if (a_orb !== 32'd2) begin failures++; $display("FAIL free_orb got=%0d exp=2", a_orb); end
    endtask

    task automatic test_lock_aligned();
        step(8);                                   // BC 7 -> 15
        bc0 = 1'b1; step(1); bc0 = 1'b0;
        checks++; if (a_bc !== 4'd0) begin failures++; $display("FAIL lock_bc got=%0d exp=0", a_bc); end
        checks++; if (a_locked !== 1'b1) begin failures++; $display("FAIL lock_locked got=%b exp=1", a_locked); end
        checks++; if (a_bc0_err !== 1'b0) begin failures++; $display("FAIL lock_err got=%b exp=0", a_bc0_err); end
        checks++; if (a_orb !== 32'd3) begin failures++; $display("FAIL lock_orb got=%0d exp=3", a_orb); end
        for (int o = 0; o < 4; o++) begin
            for (int c = 0; c < 15; c++) begin
                step(1);
                checks++; if (a_bc0_err !== 1'b0 || a_locked !== 1'b1) begin failures++; $display("FAIL aligned_run o=%0d err=%b locked=%b exp err=0 locked=1", o, a_bc0_err, a_locked); end
            end
            bc0 = 1'b1; step(1); bc0 = 1'b0;
            checks++; if (a_bc !== 4'd0 || a_bc0_err !== 1'b0 || a_locked !== 1'b1) begin failures++; $display("FAIL aligned_bc0 o=%0d bc=%0d err=%b locked=%b exp 0/0/1", o, a_bc, a_bc0_err, a_locked); end
        end
        checks++; if (a_orb !== 32'd7) begin failures++; $display("FAIL aligned_orb got=%0d exp=7", a_orb); end
    endtask

    task automatic test_misalign();
        step(7);                                   // BC 0 -> 7
        bc0 = 1'b1; step(1); bc0 = 1'b0;
        checks++; if (a_bc !== 4'd0) begin failures++; $display("FAIL mis_bc got=%0d exp=0", a_bc); end
        checks++; if (a_bc0_err !== 1'b1) begin failures++; $display("FAIL mis_err got=%b exp=1", a_bc0_err); end
        checks++; if (a_locked !== 1'b1) begin failures++; $display("FAIL mis_locked got=%b exp=1", a_locked); end
        checks++; if (a_err_cnt !== 16'(ERRC)) begin failures++; $display("FAIL mis_err_cnt got=%0d exp=%0d", a_err_cnt, ERRC); end
        checks++; if (a_orb !== 32'd8) begin failures++; $display("FAIL mis_orb got=%0d exp=8", a_orb); end
        step(1);
        checks++; if (a_bc0_err !== 1'b0 || a_bc !== 4'd1) begin failures++; $display("FAIL mis_pulse err=%b bc=%0d exp err=0 bc=1", a_bc0_err, a_bc); end
    endtask

    task automatic test_lock_loss();
        step(15);                                  // BC 1 -> 15 -> 0 (1st wrap)
        checks++; if (a_locked !== 1'b1 || a_bc !== 4'd0) begin failures++; $display("FAIL loss_wrap1 locked=%b bc=%0d exp 1/0", a_locked, a_bc); end
        step(15);
        checks++; if (a_locked !== 1'b1) begin failures++; $display("FAIL loss_pre locked=%b exp=1", a_locked); end
        step(1);                                   // 2nd wrap
        checks++; if (a_locked !== 1'b0) begin failures++; $display("FAIL loss_locked got=%b exp=0", a_locked); end
        checks++; if (a_err_cnt !== 16'(2 * ERRC)) begin failures++; $display("FAIL loss_err_cnt got=%0d exp=%0d", a_err_cnt, 2 * ERRC); end
        checks++; if (a_orb !== 32'd10 || a_bc0_err !== 1'b0) begin failures++; $display("FAIL loss_orb orb=%0d err=%b exp 10/0", a_orb, a_bc0_err); end
    endtask

    task automatic test_ec0();
        step(15);                                  // BC 0 -> 15
        ec0 = 1'b1; step(1); ec0 = 1'b0;
        checks++; if (a_orb !== 32'd0 || a_bc !== 4'd0) begin failures++; $display("FAIL ec0_wrap orb=%0d bc=%0d exp 0/0", a_orb, a_bc); end
        step(5);
        bc0 = 1'b1; ec0 = 1'b1; step(1); bc0 = 1'b0; ec0 = 1'b0;
        checks++; if (a_orb !== 32'd0 || a_bc !== 4'd0 || a_locked !== 1'b1) begin failures++; $display("FAIL ec0_bc0 orb=%0d bc=%0d locked=%b exp 0/0/1", a_orb, a_bc, a_locked); end
    endtask

    task automatic test_offset();
        do_reset();                                // EN=0
        step(2);
        checks++; if (b_bc !== 4'd0) begin failures++; $display("FAIL off_hold0 got=%0d exp=0", b_bc); end
        bc0 = 1'b1; step(1); bc0 = 1'b0;
        checks++; if (b_bc !== 4'd5 || b_locked !== 1'b1 || b_bc0_out !== 1'b0) begin failures++; $display("FAIL off_load bc=%0d locked=%b bc0_out=%b exp 5/1/0", b_bc, b_locked, b_bc0_out); end
        checks++; if (b_orb !== 8'd0 || a_orb !== 32'd0 || a_bc !== 4'd0) begin failures++; $display("FAIL off_orb b_orb=%0d a_orb=%0d a_bc=%0d exp 0/0/0", b_orb, a_orb, a_bc); end
        step(3);
        checks++; if (b_bc !== 4'd5) begin failures++; $display("FAIL off_held got=%0d exp=5", b_bc); end
        en = 1'b1; step(1);
        checks++; if (b_bc !== 4'd6) begin failures++; $display("FAIL off_count got=%0d exp=6", b_bc); end
        step(14);                                  // 6 -> 4 across one wrap
        checks++; if (b_bc !== 4'd4 || b_orb !== 8'd1) begin failures++; $display("FAIL off_pre bc=%0d orb=%0d exp 4/1", b_bc, b_orb); end
        bc0 = 1'b1; step(1); bc0 = 1'b0;
        checks++; if (b_bc !== 4'd5 || b_bc0_err !== 1'b0 || b_locked !== 1'b1) begin failures++; $display("FAIL off_aligned bc=%0d err=%b locked=%b exp 5/0/1", b_bc, b_bc0_err, b_locked); end
    endtask

    task automatic test_async_reset();
        step(3);
        checks++; if (a_bc !== 4'd3 || a_locked !== 1'b1) begin failures++; $display("FAIL ares_pre bc=%0d locked=%b exp 3/1", a_bc, a_locked); end
        #2 rst = 1'b1;
        #1;
        checks++; if (a_bc !== 4'd0 || a_orb !== 32'd0 || a_bc0_out !== 1'b1) begin failures++; $display("FAIL ares_cnt bc=%0d orb=%0d bc0_out=%b exp 0/0/1", a_bc, a_orb, a_bc0_out); end
        checks++; if (a_locked !== 1'b0 || a_bc0_err !== 1'b0 || a_err_cnt !== 16'd0) begin failures++; $display("FAIL ares_lock locked=%b err=%b err_cnt=%0d exp 0/0/0", a_locked, a_bc0_err, a_err_cnt); end
        step(1);
        rst = 1'b0;
    endtask

    task automatic test_orb_wrap();
        do_reset();
        en = 1'b1;
        step(16 * 255);
        checks++; if (b_orb !== 8'd255) begin failures++; $display("FAIL orbw_255 got=%0d exp=255", b_orb); end
        step(16);
        checks++; if (b_orb !== 8'd0 || b_bc !== 4'd0) begin failures++; $display("FAIL orbw_wrap orb=%0d bc=%0d exp 0/0", b_orb, b_bc); end
        checks++; if (a_orb !== 32'd256) begin failures++; $display("FAIL orbw_wide got=%0d exp=256", a_orb); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_lock_aligned();
        test_misalign();
        test_lock_loss();
        test_ec0();
        test_offset();
        test_async_reset();
        test_orb_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
